// File: rtl/temp_pkg.sv
// rtl/temp_pkg.sv - shared types and constants for the temperature monitor
package temp_pkg;

  localparam int TEMP_W = 4;

  typedef enum logic [1:0] {
    SYS_C   = 2'b00,
    SYS_F   = 2'b01,
    SYS_K   = 2'b10,
    SYS_BAD = 2'b11
  } sys_t;

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    PEND   = 2'b01,
    ALARM  = 2'b10
  } alarm_state_t;

endpackage

// File: rtl/temp_window_avg.sv
// rtl/temp_window_avg.sv - sliding window of samples with running sum, count and average
module temp_window_avg
  import temp_pkg::*;
#(
  parameter int WIN_LOG2 = 3
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                restart,
  input  logic                push,
  input  logic [TEMP_W-1:0]   din,
  output logic [TEMP_W-1:0]   avg,
  output logic [WIN_LOG2:0]   count,
  output logic                full
);

  localparam int DEPTH = 1 << WIN_LOG2;
  localparam int SUM_W = WIN_LOG2 + TEMP_W;
  localparam logic [WIN_LOG2:0] FULL_CNT = {1'b1, {WIN_LOG2{1'b0}}};

  logic [TEMP_W-1:0] r_win [DEPTH];
  logic [SUM_W-1:0]  r_sum;
  logic [WIN_LOG2:0] r_count;

  logic [SUM_W-1:0]  w_din_ext;
  logic [SUM_W-1:0]  w_old_ext;

  assign w_din_ext = SUM_W'(din);
  assign w_old_ext = SUM_W'(r_win[DEPTH-1]);

  // Window shift, running sum and saturating count; restart seeds a fresh window with din
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) r_win[i] <= '0;
      r_sum   <= '0;
      r_count <= '0;
    end else if (restart) begin
      r_win[0] <= din;
      for (int i = 1; i < DEPTH; i++) r_win[i] <= '0;
      r_sum   <= w_din_ext;
      r_count <= (WIN_LOG2+1)'(1);
    end else if (push) begin
      r_win[0] <= din;
      for (int i = 1; i < DEPTH; i++) r_win[i] <= r_win[i-1];
      // Unfilled slots hold 0, so subtracting the oldest keeps the sum exact while filling
      r_sum <= r_sum + w_din_ext - w_old_ext;
      if (r_count != FULL_CNT) r_count <= r_count + (WIN_LOG2+1)'(1);
    end
  end

  // Upper bits of the sum are sum >> WIN_LOG2
  assign avg   = r_sum[SUM_W-1 -: TEMP_W];
  assign count = r_count;
  assign full  = (r_count == FULL_CNT);

endmodule

// File: rtl/temp_monitor.sv
// rtl/temp_monitor.sv - min/max/average statistics and hysteresis alarm on loaded temperature samples
module temp_monitor
  import temp_pkg::*;
#(
  parameter int WIN_LOG2  = 3,
  parameter int HI_THRESH = 12,
  parameter int LO_THRESH = 9,
  parameter int HI_COUNT  = 3
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [TEMP_W-1:0]   d_in,
  input  logic [1:0]          sys_in,
  input  logic                ld,
  output logic [TEMP_W-1:0]   min_out,
  output logic [TEMP_W-1:0]   max_out,
  output logic [TEMP_W-1:0]   avg_out,
  output logic                avg_valid,
  output logic [WIN_LOG2:0]   count_out,
  output logic                valid_out,
  output logic                alarm,
  output logic                unit_err
);

  localparam logic [TEMP_W-1:0] HI_T   = TEMP_W'(HI_THRESH);
  localparam logic [TEMP_W-1:0] LO_T   = TEMP_W'(LO_THRESH);
  localparam logic [2:0]        HI_CNT = 3'(HI_COUNT);

  logic         r_ld_q;
  sys_t         r_unit;
  logic [TEMP_W-1:0] r_min;
  logic [TEMP_W-1:0] r_max;
  logic         r_valid;
  alarm_state_t r_state;
  logic [2:0]   r_hcnt;
  logic         r_alarm;
  logic         r_unit_err;

  logic         w_rise;
  logic         w_bad;
  logic         w_push;
  logic         w_restart;
  logic         w_hi;
  logic         w_lo;
  alarm_state_t w_base_state;
  logic [2:0]   w_base_hcnt;
  logic [2:0]   w_hcnt_inc;
  alarm_state_t w_next_state;
  logic [2:0]   w_next_hcnt;

  assign w_rise    = ld & ~r_ld_q;
  assign w_bad     = w_rise & (sys_t'(sys_in) == SYS_BAD);
  assign w_push    = w_rise & ~w_bad;
  assign w_restart = w_push & (sys_t'(sys_in) != r_unit);
  assign w_hi      = (d_in >= HI_T);
  assign w_lo      = (d_in <= LO_T);

  // Edge detect, stored unit and the one-cycle invalid-unit pulse
  always_ff @(posedge clk) begin
    if (clr) begin
      r_ld_q     <= 1'b0;
      r_unit     <= SYS_C;
      r_unit_err <= 1'b0;
    end else begin
      r_ld_q     <= ld;
      r_unit_err <= w_bad;
      if (w_restart) r_unit <= sys_t'(sys_in);
    end
  end

  // Running min/max; the first sample after reset or a unit change seeds both
  always_ff @(posedge clk) begin
    if (clr) begin
      r_min   <= '0;
      r_max   <= '0;
      r_valid <= 1'b0;
    end else if (w_push) begin
      r_valid <= 1'b1;
      if (w_restart || !r_valid) begin
        r_min <= d_in;
        r_max <= d_in;
      end else begin
        if (d_in < r_min) r_min <= d_in;
        if (d_in > r_max) r_max <= d_in;
      end
    end
  end

  // Alarm next-state; a unit change forces NORMAL before this sample is evaluated
  always_comb begin
    w_base_state = w_restart ? NORMAL : r_state;
    w_base_hcnt  = w_restart ? 3'd0 : r_hcnt;
    w_hcnt_inc   = w_base_hcnt + 3'd1;
    w_next_state = r_state;
    w_next_hcnt  = r_hcnt;
    if (w_push) begin
      w_next_state = w_base_state;
      w_next_hcnt  = w_base_hcnt;
      case (w_base_state)
        NORMAL: begin
          if (w_hi) begin
            w_next_hcnt  = 3'd1;
            w_next_state = (HI_CNT == 3'd1) ? ALARM : PEND;
          end
        end
        PEND: begin
          if (w_hi) begin
            w_next_hcnt = w_hcnt_inc;
            if (w_hcnt_inc >= HI_CNT) w_next_state = ALARM;
          end else begin
            w_next_state = NORMAL;
            w_next_hcnt  = 3'd0;
          end
        end
        ALARM: begin
          if (w_lo) begin
            w_next_state = NORMAL;
            w_next_hcnt  = 3'd0;
          end
        end
        default: begin
          w_next_state = NORMAL;
          w_next_hcnt  = 3'd0;
        end
      endcase
    end
  end

  // Alarm state register and its registered flag
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= NORMAL;
      r_hcnt  <= 3'd0;
      r_alarm <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_hcnt  <= w_next_hcnt;
      r_alarm <= (w_next_state == ALARM);
    end
  end

  temp_window_avg #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_window (
    .clk     (clk),
    .clr     (clr),
    .restart (w_restart),
    .push    (w_push),
    .din     (d_in),
    .avg     (avg_out),
    .count   (count_out),
    .full    (avg_valid)
  );

  assign min_out   = r_min;
  assign max_out   = r_max;
  assign valid_out = r_valid;
  assign alarm     = r_alarm;
  assign unit_err  = r_unit_err;

endmodule

// File: doc/temp_monitor.md
Name: temp_monitor

Overview:
Downstream consumer of the registered temperature/measurement-system stage.
- Inputs: the 4-bit held temperature, the 2-bit unit code and the load strobe from that stage.
- On each new load it accepts one sample and updates the running min, max and 8-sample moving average.
- A hysteresis alarm FSM flags sustained high readings.
- Outputs feed the display/indicator stage.

Parameters:
WIN_LOG2, 3, log2 of moving-average window depth (window = 8 samples)
HI_THRESH, 12, sample >= this counts as high
LO_THRESH, 9, sample <= this clears an active alarm (must be < HI_THRESH)
HI_COUNT, 3, consecutive high samples required to raise alarm (1..7)

Ports:
clk  in  1  system clock, all state on rising edge
clr  in  1  synchronous active-high reset
d_in  in  4  held temperature from upstream register
sys_in  in  2  unit code: 00 C, 01 F, 10 K, 11 invalid
ld  in  1  load level from upstream; a sample is taken on its 0->1 transition
min_out  out  4  minimum accepted sample since last restart
max_out  out  4  maximum accepted sample since last restart
avg_out  out  4  floor(window sum / 2^WIN_LOG2)
avg_valid  out  1  window full (2^WIN_LOG2 samples since restart)
count_out  out  WIN_LOG2+1  accepted samples since restart, saturates at 2^WIN_LOG2
valid_out  out  1  at least one sample held
alarm  out  1  alarm FSM in ALARM
unit_err  out  1  one-cycle pulse when a rise occurs with sys_in==11

Behaviour:
- Reset: clk and clr as above; reset is synchronous and active-high.
  - On clr, every output is 0, ld_q=0, the window and sum are 0, the stored unit is 00, and the FSM is NORMAL.
  - clr has priority over everything in the same cycle.
- Accept: rise = ld & ~ld_q, with ld_q a registered copy of ld.
  - An accepted sample updates all state at that edge; outputs are visible the following cycle (1-cycle latency).
  - ld held high accepts only once.
  - A rise in the first cycle after clr drops is accepted.
- Invalid unit: on a rise with sys_in==11, unit_err=1 for exactly one cycle. No other state changes.
- Unit change: on a rise with a valid sys_in different from the stored unit, statistics restart with this sample.
  - The window is cleared, then the sample is inserted; sum=d_in; count=1; min=max=d_in.
  - The FSM is forced to NORMAL and then evaluates this sample.
  - The stored unit is updated.
- Normal accept, same unit:
  - Shift d_in into the window: sum <= sum + d_in - oldest. Sum is WIN_LOG2+4 bits wide and cannot overflow.
  - Unfilled entries are 0, so the sum is exact before the window fills.
  - count increments and saturates at 2^WIN_LOG2; avg_valid=1 once count==2^WIN_LOG2.
  - avg_out = sum >> WIN_LOG2, truncated. It is driven continuously but is meaningful only when avg_valid=1.
  - First sample after reset: min=max=d_in, valid_out=1. After that, min/max update on strict compare.
- Alarm FSM: states NORMAL, PEND, ALARM. Transitions occur only on accepted samples. hcnt is 3 bits.
  - NORMAL: sample >= HI_THRESH → hcnt=1; go to ALARM if HI_COUNT==1, else PEND.
  - PEND: sample >= HI_THRESH → hcnt+1; go to ALARM when it reaches HI_COUNT. Sample < HI_THRESH → NORMAL, hcnt=0.
  - ALARM: sample <= LO_THRESH → NORMAL, hcnt=0. Otherwise stay, including samples between the thresholds.
  - alarm = (state==ALARM), registered.
- Mid-operation clr: everything returns to reset values at that edge; any rise in the same cycle is discarded.

Decomposition:
- Shared package temp_pkg holds:
  - sys_t enum: SYS_C, SYS_F, SYS_K, SYS_BAD.
  - alarm_state_t enum: NORMAL, PEND, ALARM.
  - TEMP_W=4 constant.
- One sub-module: temp_window_avg.
  - Contents: window shift register, running sum, count, avg_valid.
  - Ports: clk, clr, restart, push, din, avg, count, full.
- The min/max logic, edge detect and FSM live in temp_monitor.

Test Plan:
1. clr, then ld pulses with d_in=5,7,3 (sys=00) → min_out=3, max_out=7, count_out=3, valid_out=1, avg_valid=0, alarm=0.
2. 8 samples of d_in=10, then one of 2 → avg_out=10 after 8; after the 9th, sum=72 and avg_out=9; count stays 8.
3. ld held high 5 cycles with d_in=6 → exactly one accept, count_out=1. Then ld low one cycle and high again → count_out=2.
4. Samples 13,13,10 → no alarm. Then 13,14,15 → alarm=1 after the third. 11 → alarm stays 1. 9 → alarm=0.
5. Samples 4,8 at sys=00, then 6 at sys=01 → min=max=6, count=1, alarm=0. A rise with sys=11 → unit_err high for one cycle, stats unchanged.
6. Assert clr in the same cycle as a ld rise mid-window → all outputs 0 next cycle, and the sample is not counted.
